// File: rtl/tsp_icu_pkg.sv
// Shared ICU definitions: fetch FSM states, opcode field location, HALT opcode
// and the instruction word type used by both the fetch queue and the dispatcher.
package tsp_icu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    localparam logic [7:0] HALT_OPC = 8'hFF;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 24;

    typedef logic [31:0] instr_t;

endpackage

// File: rtl/icu_sync_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on pop_data whenever
// the FIFO is non-empty. Push while full is accepted only together with a pop.
module icu_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem     <= '{default: '0};
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/icu_fetch_queue.sv
// Instruction fetch stage feeding the ICU dispatcher. Walks a PC through
// instruction memory, buffers returned words and stops at the HALT opcode.
// Optional performance counters are built when ICU_FETCH_PERF_EN is defined.
module icu_fetch_queue
    import tsp_icu_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH          = 32,
    parameter int unsigned INSTR_MEM_ADDR_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH           = 4,
    parameter logic [7:0]  HALT_OPCODE          = HALT_OPC
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [INSTR_MEM_ADDR_WIDTH-1:0] start_pc,
    output logic                            imem_req,
    output logic [INSTR_MEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic                            imem_rvalid,
    input  logic [INSTR_WIDTH-1:0]          imem_rdata,
    output logic                            instr_valid,
    output logic [INSTR_WIDTH-1:0]          instr_out,
    input  logic                            instr_ready,
    output logic                            busy,
    output logic                            halted,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
`ifdef ICU_FETCH_PERF_EN
    ,
    output logic [31:0]                     perf_issued,
    output logic [31:0]                     perf_stall
`endif
);

    localparam int unsigned AW = INSTR_MEM_ADDR_WIDTH;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    fetch_state_e  state;
    fetch_state_e  state_next;
    logic [AW-1:0] pc;
    logic          req_q;
    logic [AW-1:0] addr_q;
    logic          outstanding;
    logic          start_ok;
    logic          accept;
    logic          halt_seen;
    logic          push;
    logic          pop;
    logic          issue;
    logic [SW-1:0] credit_used;
    logic          fifo_empty;
    logic          fifo_full;

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign busy      = (state == FETCH) || (state == DRAIN);
    assign halted    = (state == HALTED);

    assign start_ok  = start && ((state == IDLE) || (state == HALTED));

    // A response is meaningful only while fetching and only if we asked for it
    assign accept    = imem_rvalid && outstanding && (state == FETCH);
    assign halt_seen = accept && (imem_rdata[OPC_MSB:OPC_LSB] == HALT_OPCODE);
    assign push      = accept && !halt_seen;

    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;

    // Two reads may be in flight: the one returning now (outstanding) and the one
    // on the bus this cycle (req_q). Reserving room for both keeps one issue per
    // cycle in steady state while making overflow impossible.
    assign credit_used = SW'(fifo_count) + SW'(outstanding) + SW'(req_q);
    assign issue       = (state == FETCH) && !halt_seen && (credit_used < SW'(FIFO_DEPTH));

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)      state_next = FETCH;
            FETCH:   if (halt_seen)  state_next = DRAIN;
            DRAIN:   if (fifo_empty) state_next = HALTED;
            HALTED:  if (start)      state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // State register, PC and registered memory request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            outstanding <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= req_q;
            req_q       <= issue;
            if (issue) begin
                addr_q <= pc;
            end
            if (start_ok) begin
                pc <= start_pc;
            end else if (issue) begin
                pc <= pc + AW'(1);
            end
        end
    end

    icu_sync_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (imem_rdata),
        .pop       (pop),
        .pop_data  (instr_out),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // The credit rule must keep a lone push away from a full buffer
    assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

`ifdef ICU_FETCH_PERF_EN
    // Saturating pop and starvation counters, cleared on reset and accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else if (start_ok) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (pop && (perf_issued != '1)) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (busy && !instr_valid && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icu_fetch_queue.sv
// Directed bench for icu_fetch_queue: table of programs plus hand-written
// reset sequences, with a one-cycle-latency instruction memory model.
module tb_icu_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  start_pc;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic        instr_ready;
    logic        busy;
    logic        halted;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [1024];
    logic        mem_r;
    logic [9:0]  mem_a;

    logic [31:0] words_q [$];
    logic [9:0]  addrs_q [$];
    logic        marker_seen;

    typedef struct {
        logic [9:0] pc;
        int         n;
        int         stall;
        bit         mid_start;
        logic [9:0] halt_addr;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    icu_fetch_queue #(
        .INSTR_WIDTH          (32),
        .INSTR_MEM_ADDR_WIDTH (10),
        .FIFO_DEPTH           (4),
        .HALT_OPCODE          (8'hFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_pc    (start_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_ready (instr_ready),
        .busy        (busy),
        .halted      (halted),
        .fifo_count  (fifo_count)
    );

    // Memory answers exactly one cycle after a request; it knows nothing of reset
    always @(posedge clk) begin
        mem_r = imem_req;
        mem_a = imem_addr;
        #1;
        imem_rvalid = mem_r;
        imem_rdata  = mem[mem_a];
    end

    // Record delivered words and issued addresses mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid && instr_ready) words_q.push_back(instr_out);
            if (instr_valid && instr_out == 32'hDEAD_BEEF) marker_seen = 1'b1;
            if (imem_req) addrs_q.push_back(imem_addr);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic load_prog(input vec_t v);
        logic [9:0] a;
        for (int i = 0; i < v.n; i++) begin
            a = v.pc + 10'(i);
            mem[a] = 32'h0100_0000 + 32'(i);
        end
        mem[v.halt_addr] = 32'hFF00_0ABC;
        a = v.halt_addr + 10'd1;
        mem[a] = 32'hDEAD_BEEF;
    endtask

    task automatic pulse_start(input logic [9:0] pc);
        @(posedge clk);
        #1 start_pc = pc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_prog(input vec_t v, input int row);
        int         k;
        logic [9:0] exp_a;
        load_prog(v);
        words_q.delete();
        addrs_q.delete();
        marker_seen = 1'b0;
        instr_ready = (v.stall == 0);
        pulse_start(v.pc);
        check($sformatf("r%0d_busy_after_start", row), busy, 1);
        if (v.mid_start) begin
            repeat (4) @(posedge clk);
            pulse_start(10'h000);
        end
        if (v.stall > 0) begin
            repeat (v.stall) @(posedge clk);
            @(negedge clk);
            check($sformatf("r%0d_stall_count_full", row), fifo_count, 4);
            check($sformatf("r%0d_stall_req_stopped", row), imem_req, 0);
            @(posedge clk);
            #1 instr_ready = 1'b1;
        end
        k = 0;
        while (!halted && k < 400) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("r%0d_halted", row), halted, 1);
        check($sformatf("r%0d_busy_end", row), busy, 0);
        check($sformatf("r%0d_count_end", row), fifo_count, 0);
        check($sformatf("r%0d_num_words", row), words_q.size(), v.n);
        for (int i = 0; i < v.n && i < words_q.size(); i++)
            check($sformatf("r%0d_word%0d", row, i), words_q[i], 32'h0100_0000 + 32'(i));
        check($sformatf("r%0d_num_addrs", row), (addrs_q.size() >= v.n + 1), 1);
        for (int i = 0; i <= v.n && i < addrs_q.size(); i++) begin
            exp_a = v.pc + 10'(i);
            check($sformatf("r%0d_addr%0d", row, i), addrs_q[i], exp_a);
        end
        if (addrs_q.size() > v.n)
            check($sformatf("r%0d_halt_addr", row), addrs_q[v.n], v.halt_addr);
        check($sformatf("r%0d_discarded_word_hidden", row), marker_seen, 0);
    endtask

    initial begin
        int   k;
        vec_t v;

        vecs[0] = '{pc: 10'h010, n: 6,  stall: 0,  mid_start: 1'b0, halt_addr: 10'h016};
        vecs[1] = '{pc: 10'h100, n: 8,  stall: 10, mid_start: 1'b0, halt_addr: 10'h108};
        vecs[2] = '{pc: 10'h3FE, n: 3,  stall: 0,  mid_start: 1'b0, halt_addr: 10'h001};
        vecs[3] = '{pc: 10'h020, n: 0,  stall: 0,  mid_start: 1'b0, halt_addr: 10'h020};
        vecs[4] = '{pc: 10'h300, n: 12, stall: 0,  mid_start: 1'b1, halt_addr: 10'h30C};

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0200_0000 + 32'(i);

        rst         = 1'b1;
        start       = 1'b0;
        start_pc    = '0;
        instr_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        marker_seen = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr_out", instr_out, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_fifo_count", fifo_count, 0);
        rst = 1'b0;

        // Rows run back to back, so every row after the first restarts from HALTED
        for (int r = 0; r < 5; r++) run_prog(vecs[r], r);

        // Asynchronous reset with three words buffered and a read in flight
        v = '{pc: 10'h200, n: 10, stall: 0, mid_start: 1'b0, halt_addr: 10'h20A};
        load_prog(v);
        instr_ready = 1'b0;
        pulse_start(v.pc);
        k = 0;
        while (fifo_count != 3 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("mid_rst_reached_count3", fifo_count, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_imem_req", imem_req, 0);
        check("mid_rst_imem_addr", imem_addr, 0);
        check("mid_rst_instr_valid", instr_valid, 0);
        check("mid_rst_instr_out", instr_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_halted", halted, 0);
        check("mid_rst_fifo_count", fifo_count, 0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("late_rvalid_count", fifo_count, 0);
        check("late_rvalid_valid", instr_valid, 0);
        check("late_rvalid_busy", busy, 0);

        // Fetching works again from IDLE after the reset
        v = '{pc: 10'h050, n: 2, stall: 0, mid_start: 1'b0, halt_addr: 10'h052};
        run_prog(v, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
